vga_timing_gen: RTL

- Generates 640x480@60 VGA raster timing from the 25 MHz pixel clock.
- Produces the DrawX/DrawY scan coordinates and the active-video flag (blank) consumed by every sprite/background mapper downstream.
- Produces the hs/vs sync outputs for the VGA connector.
- Adds a one-cycle frame_start strobe, used to latch game state between frames.

---
 rtl/vga_timing_gen.sv | 109 ++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster timing generator.
// A free-running horizontal/vertical counter pair produces the DrawX/DrawY
// scan coordinates. Every decoded output (hs, vs, blank, frame_start,
// line_end) is derived from the *next* counter values and registered, so it
// lands on exactly the same cycle as the coordinate it describes.

module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start,
    output logic       line_end
);

    // Raster geometry.
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // The counters are fixed at 10 bits; a larger raster cannot be represented.
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be <= 1024");
        end
    endgenerate

    // Decode thresholds, sized to the counter width.
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] x_next;
    logic [9:0] y_next;
    logic       x_wrap;
    logic       hs_next;
    logic       vs_next;
    logic       blank_next;
    logic       frame_start_next;
    logic       line_end_next;

    // Next raster position plus everything decoded from it.
    always_comb begin
        x_wrap = (DrawX == H_LAST);

        if (x_wrap) begin
            x_next = 10'd0;
        end else begin
            x_next = DrawX + 10'd1;
        end

        if (x_wrap) begin
            if (DrawY == V_LAST) begin
                y_next = 10'd0;
            end else begin
                y_next = DrawY + 10'd1;
            end
        end else begin
            y_next = DrawY;
        end

        hs_next    = !((x_next >= H_SYNC_START) && (x_next < H_SYNC_END));
        vs_next    = !((y_next >= V_SYNC_START) && (y_next < V_SYNC_END));
        blank_next = (x_next < H_VIS_END) && (y_next < V_VIS_END);

        // (0,0) is only ever reached through a wrap here; the reset-initialised
        // (0,0) comes from the reset branch, so the first frame gets no pulse.
        frame_start_next = (x_next == 10'd0) && (y_next == 10'd0);
        line_end_next    = (x_next == H_LAST);
    end

    // Output registers; reset parks the raster at (0,0) with syncs idle.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= 10'd0;
            DrawY       <= 10'd0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b1;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
        end else begin
            DrawX       <= x_next;
            DrawY       <= y_next;
            hs          <= hs_next;
            vs          <= vs_next;
            blank       <= blank_next;
            frame_start <= frame_start_next;
            line_end    <= line_end_next;
        end
    end

endmodule
